alu_decode_unit: RTL and testbench
==================================

Name: alu_decode_unit

Overview:
- Combines the instruction decoder and the 16-bit ALU of the single-cycle CPU core.
- Decodes the 32-bit ROM word at the current IP into unit selects, register addresses, immediates and a 4-bit optype.
- Computes the ALU result from the resolved argument-bus values.
- Holds a small registered state: a halt latch and ALU flags.

Parameters:
- DATA_SIZE, 16, width of operands, immediates and ALU result.
- REG_ADDR_SIZE, 4, register-file address width.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous reset, ACTIVE-HIGH despite the codebase name; one clock domain.
- instr  input  32  instruction word.
- lhs  input  16  resolved argument 1 from the argument bus.
- rhs  input  16  resolved argument 2 from the argument bus.
- alu_out, comp_out, misc_cs, maybe_jmp  output  1 each  unit selects for the output bus.
- ip_incr  output  1  advance IP.
- use_r1, use_r2  output  1 each  argument comes from a register (1) or an immediate (0).
- reg_we  output  1  register-file write enable.
- r1_addr, r2_addr, rw_addr  output  4 each  register addresses.
- default_a1, default_a2  output  16 each  immediate values.
- optype  output  4  operation code for ALU, comparator, misc unit and jump unit.
- alu_result  output  16  combinational ALU result.
- flag_z, flag_c  output  1 each  registered ALU zero and carry flags.
- halted  output  1  registered halt state.

Behaviour:
- Instruction fields:
  - [31:30] unit: 00 ALU, 01 compare, 10 misc, 11 jump.
  - [29:26] optype.
  - [25] use_r1; [24] use_r2.
  - [23:20] rw_addr.
  - [19:10] arg1 field; [9:0] arg2 field.
- Address and immediate decode:
  - r1_addr = instr[13:10]; r2_addr = instr[3:0].
  - default_a1 = sign-extend(instr[19:10]) when use_r1 = 0, else 0. default_a2 likewise from [9:0].
- Unit selects are one-hot from the unit field: alu_out for 00, comp_out for 01, misc_cs for 10, maybe_jmp for 11.
- reg_we:
  - 1 for ALU and compare.
  - For misc, equals optype[0] (1 = read port into register, 0 = write port).
  - 0 for jump.
- ip_incr = 1 for every instruction except HALT. Jump override is external.
- HALT (instr == 32'hFFFF_FFFF):
  - All selects, reg_we and ip_incr are 0.
  - The halt latch sets on the next rising edge.
- While halted = 1: all selects, reg_we and ip_incr are forced to 0 regardless of instr.
- ALU: op = optype[3:1]; optype[0] is ignored for ALU. All results are truncated to 16 bits.
  - 000 add, 001 sub (lhs - rhs), 010 and, 011 or, 100 xor.
  - 101 shl by rhs[3:0]; 110 logical shr by rhs[3:0].
  - 111 multiply, low 16 bits of the product.
- alu_result is computed combinationally every cycle, for any unit.
- Flags update on a rising edge only when alu_out = 1 (ALU instruction, not halted):
  - flag_z = (alu_result == 0).
  - flag_c = carry-out for add; borrow (lhs < rhs unsigned) for sub; 0 for all other ops.
- Reset (rstn = 1 at a rising edge): halted = 0, flag_z = 0, flag_c = 0. Reset has priority over HALT and flag updates in the same cycle.
- Combinational outputs have zero latency; registered outputs have one-cycle latency.

Test Plan:
- ALU add: instr 0x0000_0000 (unit 00, op 000), lhs = 0xFFFF, rhs = 0x0001 -> alu_result 0x0000, alu_out 1, reg_we 1; after the edge flag_z 1, flag_c 1.
- Immediate decode: unit 00, use_r1 0, arg1 field 0x3FF, use_r2 1, arg2 field 0x005 -> default_a1 0xFFFF, r2_addr 5, use_r2 1.
- Shifts and multiply: lhs 0x8001, rhs 0x0001 -> shl 0x0002; shr 0x4000; mul 0x8001.
- Unit select: unit 11 -> maybe_jmp 1, reg_we 0, ip_incr 1. Unit 10 with optype 0001 -> misc_cs 1, reg_we 1; with optype 0000 -> reg_we 0.
- HALT: instr 0xFFFF_FFFF -> ip_incr 0 immediately, halted 1 after the edge. A following ALU instruction keeps alu_out 0 and the flags unchanged.
- Reset: assert rstn for one edge while halted with flag_z = 1 -> halted 0, flags 0. An ALU instruction in the same cycle as reset does not update the flags.

Source files
------------

// File: rtl/alu_decode_unit.sv
// alu_decode_unit: instruction decoder plus 16-bit ALU for the single-cycle core.
//
// Decodes the ROM word at the current IP into output-bus unit selects, register
// addresses, sign-extended immediates and a 4-bit optype. The ALU result is computed
// combinationally from the resolved argument-bus values. Registered state is the halt
// latch and the ALU zero/carry flags.
//
// Ports:
//   clk                 rising-edge clock
//   rstn                synchronous reset, active high (name kept from the codebase)
//   instr               32-bit instruction word
//   lhs, rhs            resolved arguments from the argument bus
//   alu_out, comp_out,
//   misc_cs, maybe_jmp  one-hot unit selects for the output bus
//   ip_incr             advance IP (jump override is external)
//   use_r1, use_r2      argument comes from a register (1) or an immediate (0)
//   reg_we              register-file write enable
//   r1_addr, r2_addr,
//   rw_addr             register addresses
//   default_a1,
//   default_a2          immediate values (0 when the register is used)
//   optype              operation code shared by ALU, comparator, misc and jump units
//   alu_result          combinational ALU result
//   flag_z, flag_c      registered zero and carry flags
//   halted              registered halt state
module alu_decode_unit #(
  parameter int unsigned DATA_SIZE     = 16,
  parameter int unsigned REG_ADDR_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [31:0]              instr,
  input  logic [DATA_SIZE-1:0]     lhs,
  input  logic [DATA_SIZE-1:0]     rhs,
  output logic                     alu_out,
  output logic                     comp_out,
  output logic                     misc_cs,
  output logic                     maybe_jmp,
  output logic                     ip_incr,
  output logic                     use_r1,
  output logic                     use_r2,
  output logic                     reg_we,
  output logic [REG_ADDR_SIZE-1:0] r1_addr,
  output logic [REG_ADDR_SIZE-1:0] r2_addr,
  output logic [REG_ADDR_SIZE-1:0] rw_addr,
  output logic [DATA_SIZE-1:0]     default_a1,
  output logic [DATA_SIZE-1:0]     default_a2,
  output logic [3:0]               optype,
  output logic [DATA_SIZE-1:0]     alu_result,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic                     halted
);

  typedef enum logic [1:0] {
    UnitAlu  = 2'b00,
    UnitComp = 2'b01,
    UnitMisc = 2'b10,
    UnitJmp  = 2'b11
  } unit_e;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpMul = 3'b111
  } alu_op_e;

  logic                 halted_q, halted_d;
  logic                 flag_z_q, flag_z_d;
  logic                 flag_c_q, flag_c_d;
  unit_e                unit;
  alu_op_e              alu_op;
  logic                 is_halt;
  logic                 active;
  logic [9:0]           arg1_field;
  logic [9:0]           arg2_field;
  logic [DATA_SIZE:0]   sum;
  logic [2*DATA_SIZE-1:0] prod;
  logic                 alu_carry;

  // Field decode
  assign unit       = unit_e'(instr[31:30]);
  assign optype     = instr[29:26];
  assign use_r1     = instr[25];
  assign use_r2     = instr[24];
  assign rw_addr    = instr[20 +: REG_ADDR_SIZE];
  assign arg1_field = instr[19:10];
  assign arg2_field = instr[9:0];
  assign r1_addr    = instr[10 +: REG_ADDR_SIZE];
  assign r2_addr    = instr[0 +: REG_ADDR_SIZE];

  assign default_a1 = use_r1 ? '0 : {{(DATA_SIZE-10){arg1_field[9]}}, arg1_field};
  assign default_a2 = use_r2 ? '0 : {{(DATA_SIZE-10){arg2_field[9]}}, arg2_field};

  // The all-ones word is HALT even though its unit field reads as jump.
  assign is_halt = (instr == 32'hFFFF_FFFF);
  assign active  = !is_halt && !halted_q;

  always_comb begin
    alu_out   = 1'b0;
    comp_out  = 1'b0;
    misc_cs   = 1'b0;
    maybe_jmp = 1'b0;
    reg_we    = 1'b0;
    ip_incr   = 1'b0;
    if (active) begin
      ip_incr = 1'b1;
      unique case (unit)
        UnitAlu: begin
          alu_out = 1'b1;
          reg_we  = 1'b1;
        end
        UnitComp: begin
          comp_out = 1'b1;
          reg_we   = 1'b1;
        end
        UnitMisc: begin
          misc_cs = 1'b1;
          // optype[0]: 1 reads a port into a register, 0 writes a port.
          reg_we  = optype[0];
        end
        UnitJmp: begin
          maybe_jmp = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ALU; optype[0] does not affect the operation.
  assign alu_op = alu_op_e'(optype[3:1]);
  assign sum    = {1'b0, lhs} + {1'b0, rhs};
  assign prod   = {{DATA_SIZE{1'b0}}, lhs} * {{DATA_SIZE{1'b0}}, rhs};

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    unique case (alu_op)
      OpAdd: begin
        alu_result = sum[DATA_SIZE-1:0];
        alu_carry  = sum[DATA_SIZE];
      end
      OpSub: begin
        alu_result = lhs - rhs;
        alu_carry  = (lhs < rhs);
      end
      OpAnd:   alu_result = lhs & rhs;
      OpOr:    alu_result = lhs | rhs;
      OpXor:   alu_result = lhs ^ rhs;
      OpShl:   alu_result = lhs << rhs[3:0];
      OpShr:   alu_result = lhs >> rhs[3:0];
      OpMul:   alu_result = prod[DATA_SIZE-1:0];
      default: alu_result = '0;
    endcase
  end

  // Next state: halt latch is sticky until reset; flags follow ALU instructions only.
  always_comb begin
    halted_d = halted_q | is_halt;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (alu_out) begin
      flag_z_d = (alu_result == '0);
      flag_c_d = alu_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      halted_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign halted = halted_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_alu_decode_unit.sv
// Directed self-checking bench for alu_decode_unit.
module tb_alu_decode_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] instr;
  logic [15:0] lhs, rhs;
  logic        alu_out, comp_out, misc_cs, maybe_jmp, ip_incr;
  logic        use_r1, use_r2, reg_we;
  logic [3:0]  r1_addr, r2_addr, rw_addr;
  logic [15:0] default_a1, default_a2;
  logic [3:0]  optype;
  logic [15:0] alu_result;
  logic        flag_z, flag_c, halted;

  int n_checks = 0;
  int n_errors = 0;

  alu_decode_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .instr      (instr),
    .lhs        (lhs),
    .rhs        (rhs),
    .alu_out    (alu_out),
    .comp_out   (comp_out),
    .misc_cs    (misc_cs),
    .maybe_jmp  (maybe_jmp),
    .ip_incr    (ip_incr),
    .use_r1     (use_r1),
    .use_r2     (use_r2),
    .reg_we     (reg_we),
    .r1_addr    (r1_addr),
    .r2_addr    (r2_addr),
    .rw_addr    (rw_addr),
    .default_a1 (default_a1),
    .default_a2 (default_a2),
    .optype     (optype),
    .alu_result (alu_result),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs and let combinational outputs settle.
  task automatic drive(input logic [31:0] i, input logic [15:0] a, input logic [15:0] b);
    instr = i;
    lhs   = a;
    rhs   = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU op table: instr, lhs, rhs, expected result
  typedef struct {
    string       tag;
    logic [31:0] i;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
  } alu_vec_t;

  alu_vec_t alu_vecs[8];

  initial begin
    alu_vecs[0] = '{"add_opbit0", 32'h0400_0000, 16'h0002, 16'h0003, 16'h0005};
    alu_vecs[1] = '{"sub",        32'h0800_0000, 16'h0003, 16'h0005, 16'hFFFE};
    alu_vecs[2] = '{"and",        32'h1000_0000, 16'hF0F0, 16'hFF00, 16'hF000};
    alu_vecs[3] = '{"or",         32'h1800_0000, 16'hF0F0, 16'hFF00, 16'hFFF0};
    alu_vecs[4] = '{"xor",        32'h2000_0000, 16'hF0F0, 16'hFF00, 16'h0FF0};
    alu_vecs[5] = '{"shl",        32'h2800_0000, 16'h8001, 16'h0001, 16'h0002};
    alu_vecs[6] = '{"shr",        32'h3000_0000, 16'h8001, 16'h0001, 16'h4000};
    alu_vecs[7] = '{"mul",        32'h3800_0000, 16'h8001, 16'h0001, 16'h8001};

    rstn = 1'b1;
    drive(32'h0000_0000, 16'h0, 16'h0);
    tick();
    rstn = 1'b0;
    check("rst_halted", halted, 0);
    check("rst_flag_z", flag_z, 0);
    check("rst_flag_c", flag_c, 0);

    // Add with wraparound
    drive(32'h0000_0000, 16'hFFFF, 16'h0001);
    check("add_result", alu_result, 16'h0000);
    check("add_alu_out", alu_out, 1);
    check("add_reg_we", reg_we, 1);
    check("add_ip_incr", ip_incr, 1);
    tick();
    check("add_flag_z", flag_z, 1);
    check("add_flag_c", flag_c, 1);

    foreach (alu_vecs[k]) begin
      drive(alu_vecs[k].i, alu_vecs[k].a, alu_vecs[k].b);
      check(alu_vecs[k].tag, alu_result, alu_vecs[k].r);
    end

    // Sub borrow sets carry, nonzero result clears zero
    drive(32'h0800_0000, 16'h0003, 16'h0005);
    tick();
    check("sub_flag_z", flag_z, 0);
    check("sub_flag_c", flag_c, 1);
    // Logic op clears carry, zero result sets zero
    drive(32'h1000_0000, 16'h00FF, 16'hFF00);
    tick();
    check("and_flag_z", flag_z, 1);
    check("and_flag_c", flag_c, 0);

    // Immediate decode
    drive(32'h010F_FC05, 16'h0, 16'h0);
    check("imm_a1_neg", default_a1, 16'hFFFF);
    check("imm_a2_reg", default_a2, 16'h0000);
    check("imm_r2_addr", r2_addr, 4'h5);
    check("imm_r1_addr", r1_addr, 4'hF);
    check("imm_use_r2", use_r2, 1);
    check("imm_use_r1", use_r1, 0);
    drive(32'h02A7_FE00, 16'h0, 16'h0);
    check("imm_a1_pos_reg", default_a1, 16'h0000);
    check("imm_a2_neg", default_a2, 16'hFE00);
    check("imm_rw_addr", rw_addr, 4'hA);
    check("imm_use_r1_set", use_r1, 1);

    // Unit selects; non-ALU units must leave flags alone (z=1, c=0 now)
    drive(32'hC000_0000, 16'h0001, 16'h0001);
    check("jmp_sel", maybe_jmp, 1);
    check("jmp_alu_out", alu_out, 0);
    check("jmp_reg_we", reg_we, 0);
    check("jmp_ip_incr", ip_incr, 1);
    tick();
    check("jmp_flag_z_kept", flag_z, 1);
    drive(32'h8400_0000, 16'h0, 16'h0);
    check("misc_sel", misc_cs, 1);
    check("misc_rd_we", reg_we, 1);
    check("misc_optype", optype, 4'h1);
    drive(32'h8000_0000, 16'h0, 16'h0);
    check("misc_wr_we", reg_we, 0);
    drive(32'h4000_0000, 16'h0001, 16'h0001);
    check("comp_sel", comp_out, 1);
    check("comp_reg_we", reg_we, 1);
    check("comp_alu_out", alu_out, 0);
    tick();
    check("comp_flag_z_kept", flag_z, 1);

    // HALT with flags z=1 c=1
    drive(32'h0000_0000, 16'hFFFF, 16'h0001);
    tick();
    drive(32'hFFFF_FFFF, 16'h0001, 16'h0001);
    check("halt_ip_incr", ip_incr, 0);
    check("halt_jmp", maybe_jmp, 0);
    check("halt_reg_we", reg_we, 0);
    check("halt_not_yet", halted, 0);
    tick();
    check("halt_latched", halted, 1);
    check("halt_flag_z", flag_z, 1);
    check("halt_flag_c", flag_c, 1);
    drive(32'h0000_0000, 16'h0001, 16'h0001);
    check("halted_alu_out", alu_out, 0);
    check("halted_reg_we", reg_we, 0);
    check("halted_ip_incr", ip_incr, 0);
    tick();
    check("halted_flag_z", flag_z, 1);
    check("halted_flag_c", flag_c, 1);
    check("halted_sticky", halted, 1);

    // Reset while halted
    rstn = 1'b1;
    tick();
    check("rst2_halted", halted, 0);
    check("rst2_flag_z", flag_z, 0);
    check("rst2_flag_c", flag_c, 0);
    // Reset beats a live ALU instruction and a HALT
    drive(32'h0000_0000, 16'hFFFF, 16'h0001);
    check("rst_alu_active", alu_out, 1);
    tick();
    check("rst_alu_flag_z", flag_z, 0);
    check("rst_alu_flag_c", flag_c, 0);
    drive(32'hFFFF_FFFF, 16'h0, 16'h0);
    tick();
    check("rst_halt_prio", halted, 0);
    rstn = 1'b0;
    drive(32'h0000_0000, 16'hFFFF, 16'h0001);
    tick();
    check("post_rst_flag_z", flag_z, 1);
    check("post_rst_flag_c", flag_c, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
